// File: rtl/pci_master_cmd_arb_if.sv
// pci_master_cmd_arb_if: command, response and segment bus bundle for pci_master_cmd_arb.
interface pci_master_cmd_arb_if #(
  parameter int NCH    = 4,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 8,
  parameter int ADDR_W = 64
);
  logic [NCH*ID_W-1:0]   s_cmd_id;
  logic [NCH*LEN_W-1:0]  s_cmd_len;
  logic [NCH*ADDR_W-1:0] s_cmd_addr;
  logic [NCH-1:0]        s_cmd_write;
  logic [NCH-1:0]        s_cmd_valid;
  logic [NCH-1:0]        s_cmd_ready;
  logic [ID_W-1:0]       s_resp_id;
  logic [LEN_W-1:0]      s_resp_len;
  logic [1:0]            s_resp_err;
  logic [NCH-1:0]        s_resp_valid;
  logic [NCH-1:0]        s_resp_ready;
  logic [ID_W-1:0]       m_cmd_id;
  logic [LEN_W-1:0]      m_cmd_len;
  logic [ADDR_W-1:0]     m_cmd_addr;
  logic                  m_cmd_write;
  logic                  m_cmd_valid;
  logic                  m_cmd_ready;
  logic [1:0]            m_resp_err;
  logic                  m_resp_valid;
  logic                  m_resp_ready;
  logic                  busy;
  modport slave (
    input  s_cmd_id, s_cmd_len, s_cmd_addr, s_cmd_write, s_cmd_valid, s_resp_ready,
           m_cmd_ready, m_resp_err, m_resp_valid,
    output s_cmd_ready, s_resp_id, s_resp_len, s_resp_err, s_resp_valid,
           m_cmd_id, m_cmd_len, m_cmd_addr, m_cmd_write, m_cmd_valid, m_resp_ready, busy
  );
  modport master (
    output s_cmd_id, s_cmd_len, s_cmd_addr, s_cmd_write, s_cmd_valid, s_resp_ready,
           m_cmd_ready, m_resp_err, m_resp_valid,
    input  s_cmd_ready, s_resp_id, s_resp_len, s_resp_err, s_resp_valid,
           m_cmd_id, m_cmd_len, m_cmd_addr, m_cmd_write, m_cmd_valid, m_resp_ready, busy
  );
endinterface

// File: rtl/pci_master_cmd_arb.sv
// pci_master_cmd_arb: arbitrates NCH command channels, splits commands into boundary-aligned
// PCI segments and merges per-segment completions into one response per command.
module pci_master_cmd_arb #(
  parameter int NCH       = 4,
  parameter int ID_W      = 4,
  parameter int LEN_W     = 8,
  parameter int ADDR_W    = 64,
  parameter int MAX_BURST = 16,
  parameter int TAG_DEPTH = 4,
  parameter int PRIO_MODE = 0
) (
  input logic clk,
  input logic rst,
  pci_master_cmd_arb_if.slave bus
);
  localparam int CW = $clog2(NCH);
  localparam int TW = $clog2(TAG_DEPTH);
  localparam int AW = (TW > 0) ? TW : 1;
  localparam int RW = LEN_W + 1;
  typedef enum logic {IDLE, SPLIT} state_t;
  typedef struct packed {
    logic [CW-1:0]    chan;
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
    logic             last;
  } tag_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     rr_q, rr_d, chan_q, chan_d, gnt;
  logic [ID_W-1:0]   id_q, id_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [RW-1:0]     rem_q, rem_d, seg;
  logic [31:0]       wofs, room, rem32, seg32;
  logic              any, last, push, pop, full, m_cmd_valid;
  logic [NCH-1:0]    s_cmd_ready;
  tag_t              mem_q [TAG_DEPTH];
  tag_t              tag_d, head;
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [TW:0]       cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [CW-1:0]     rchan_q, rchan_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [LEN_W-1:0]  rlen_q, rlen_d;
  logic [1:0]        rerr_q, rerr_d, errm_q, errm_d, merged;
  int                k;
  // Iterating from the far end lets the lowest offset from the start point win.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    k = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      k = (PRIO_MODE != 0) ? i : (int'(rr_q) + i) % NCH;
      if (bus.s_cmd_valid[k]) begin
        gnt = CW'(k);
        any = 1'b1;
      end
    end
  end
  always_comb begin
    wofs  = 32'((addr_q >> 2) & ADDR_W'(MAX_BURST - 1));
    room  = 32'(MAX_BURST) - wofs;
    rem32 = 32'(rem_q);
    seg32 = (rem32 < room) ? rem32 : room;
    seg   = RW'(seg32);
    last  = rem_q == seg;
    full  = cnt_q == (TW+1)'(TAG_DEPTH);
    m_cmd_valid = (state_q == SPLIT) && !full;
  end
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    chan_d = chan_q;
    id_d = id_q;
    len_d = len_q;
    addr_d = addr_q;
    write_d = write_q;
    rem_d = rem_q;
    s_cmd_ready = '0;
    push = 1'b0;
    if (state_q == IDLE) begin
      if (any) begin
        s_cmd_ready[gnt] = 1'b1;
        chan_d = gnt;
        id_d = bus.s_cmd_id[gnt*ID_W +: ID_W];
        len_d = bus.s_cmd_len[gnt*LEN_W +: LEN_W];
        addr_d = bus.s_cmd_addr[gnt*ADDR_W +: ADDR_W];
        write_d = bus.s_cmd_write[gnt];
        rem_d = RW'(bus.s_cmd_len[gnt*LEN_W +: LEN_W]) + RW'(1);
        rr_d = (gnt == CW'(NCH - 1)) ? '0 : gnt + CW'(1);
        state_d = SPLIT;
      end
    end else if (m_cmd_valid && bus.m_cmd_ready) begin
      push = 1'b1;
      addr_d = addr_q + (ADDR_W'(seg) << 2);
      rem_d = rem_q - seg;
      state_d = last ? IDLE : SPLIT;
    end
  end
  // Segments of one command are contiguous in the tag FIFO, so one error accumulator suffices.
  always_comb begin
    tag_d = '{chan: chan_q, id: id_q, len: len_q, last: last};
    head = mem_q[rd_q];
    pop = bus.m_resp_valid && bus.m_resp_ready;
    merged = (bus.m_resp_err > errm_q) ? bus.m_resp_err : errm_q;
    wr_d = push ? ((wr_q == AW'(TAG_DEPTH - 1)) ? '0 : wr_q + AW'(1)) : wr_q;
    rd_d = pop ? ((rd_q == AW'(TAG_DEPTH - 1)) ? '0 : rd_q + AW'(1)) : rd_q;
    cnt_d = cnt_q + (TW+1)'(push) - (TW+1)'(pop);
    pend_d = (pend_q && bus.s_resp_ready[rchan_q]) ? 1'b0 : pend_q;
    rchan_d = rchan_q;
    rid_d = rid_q;
    rlen_d = rlen_q;
    rerr_d = rerr_q;
    errm_d = errm_q;
    if (pop) begin
      errm_d = head.last ? 2'b00 : merged;
      if (head.last) begin
        pend_d = 1'b1;
        rchan_d = head.chan;
        rid_d = head.id;
        rlen_d = head.len;
        rerr_d = merged;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      rr_q <= '0;
      chan_q <= '0;
      id_q <= '0;
      len_q <= '0;
      addr_q <= '0;
      write_q <= 1'b0;
      rem_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      pend_q <= 1'b0;
      rchan_q <= '0;
      rid_q <= '0;
      rlen_q <= '0;
      rerr_q <= '0;
      errm_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      chan_q <= chan_d;
      id_q <= id_d;
      len_q <= len_d;
      addr_q <= addr_d;
      write_q <= write_d;
      rem_q <= rem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      rchan_q <= rchan_d;
      rid_q <= rid_d;
      rlen_q <= rlen_d;
      rerr_q <= rerr_d;
      errm_q <= errm_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= tag_d;
  assign bus.s_cmd_ready  = s_cmd_ready;
  assign bus.m_cmd_valid  = m_cmd_valid;
  assign bus.m_cmd_id     = id_q;
  assign bus.m_cmd_addr   = addr_q;
  assign bus.m_cmd_write  = write_q;
  assign bus.m_cmd_len    = (state_q == SPLIT) ? LEN_W'(seg - RW'(1)) : '0;
  assign bus.m_resp_ready = (cnt_q != '0) && !pend_q;
  assign bus.s_resp_valid = pend_q ? (NCH'(1) << rchan_q) : '0;
  assign bus.s_resp_id    = rid_q;
  assign bus.s_resp_len   = rlen_q;
  assign bus.s_resp_err   = rerr_q;
  assign bus.busy         = (state_q == SPLIT) || (cnt_q != '0) || pend_q;
endmodule
